tmds_channel_decoder: RTL and testbench

//  Receive side of one TMDS/DVI-D lane: deserialises 2 bits/cycle from a DDR input pair in the clk_x5 domain
//  (5 cycles per 10-bit symbol) and finds symbol alignment by hunting for runs of control tokens.

---
 rtl/tmds_channel_decoder_if.sv | 14 +
 rtl/tmds_channel_decoder.sv | 171 +++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tmds_channel_decoder_if.sv
// Lane-side bundle of one TMDS channel decoder: serial bit pair in,
// decoded symbol stream and lock status out.
interface tmds_channel_decoder_if;
    logic [1:0] din;
    logic       sym_valid;
    logic [7:0] data;
    logic [1:0] ctl;
    logic       de;
    logic       locked;

    // master: serial source / symbol consumer; slave: the decoder itself
    modport master (output din, input sym_valid, data, ctl, de, locked);
    modport slave  (input din, output sym_valid, data, ctl, de, locked);
endinterface

// File: rtl/tmds_channel_decoder.sv
// One TMDS/DVI-D receive lane: 2-bit/cycle deserialiser, control-token
// alignment hunter with lock/loss tracking, and 10b->8b symbol decoder.
module tmds_channel_decoder #(
    parameter int CTL_RUN = 8,     // aligned tokens in a row needed for lock (2..15)
    parameter int MAX_GAP = 2047   // symbols without a token before lock drops (1..4095)
) (
    input logic             clk_x5,
    input logic             reset,
    tmds_channel_decoder_if.slave bus
);
    typedef enum logic [1:0] {HUNT, SLIP, LOCKED} state_t;

    localparam logic [3:0]  RUN_LAST = 4'(CTL_RUN - 1);
    localparam logic [11:0] GAP_LAST = 12'(MAX_GAP - 1);

    state_t      state, state_nxt;
    logic [10:0] sr;
    logic [2:0]  phase;
    logic        hold, off;
    logic [3:0]  run_cnt, run_nxt;
    logic [11:0] gap_cnt, gap_nxt;
    logic [9:0]  word;
    logic        strobe, is_tok, slip, emit, lock_set, lock_clr;
    logic [1:0]  tok_ctl;
    logic        sym_valid_q, de_q, locked_q;
    logic [7:0]  data_q;
    logic [1:0]  ctl_q;

    // TMDS transition-minimised decode: undo optional inversion, then XOR/XNOR chain
    function automatic logic [7:0] tmds_dec(input logic [9:0] w);
        logic [7:0] q, d;
        q    = w[9] ? ~w[7:0] : w[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++)
            d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    // The extra 11th bit lets a one-bit window shift without touching the phase counter
    assign word   = off ? sr[10:1] : sr[9:0];
    assign strobe = (phase == 3'd4) && !hold;

    // Recognise the four control tokens
    always_comb begin
        is_tok  = 1'b1;
        tok_ctl = 2'b00;
        case (word)
            10'b1101010100: tok_ctl = 2'b00;
            10'b0010101011: tok_ctl = 2'b01;
            10'b0101010100: tok_ctl = 2'b10;
            10'b1010101011: tok_ctl = 2'b11;
            default:        is_tok  = 1'b0;
        endcase
    end

    // Deserialiser, symbol phase and bit-slip window; a slip from off=1 back to
    // off=0 stretches the symbol by one cycle so every slip advances one bit
    always_ff @(posedge clk_x5) begin
        if (reset) begin
            sr    <= '0;
            phase <= '0;
            hold  <= 1'b0;
            off   <= 1'b0;
        end else begin
            sr   <= {bus.din[1], bus.din[0], sr[10:2]};
            hold <= slip && off;
            if (slip) off <= !off;
            if (phase == 3'd4) begin
                if (!(slip && off)) phase <= 3'd0;
            end else begin
                phase <= phase + 3'd1;
            end
        end
    end

    // Alignment state and run/gap counters
    always_ff @(posedge clk_x5) begin
        if (reset) begin
            state   <= HUNT;
            run_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            run_cnt <= run_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    // Next-state: count tokens while hunting, slip on garbage, watch the token gap once locked
    always_comb begin
        state_nxt = state;
        run_nxt   = run_cnt;
        gap_nxt   = gap_cnt;
        slip      = 1'b0;
        emit      = 1'b0;
        lock_set  = 1'b0;
        lock_clr  = 1'b0;
        if (strobe) begin
            case (state)
                HUNT: begin
                    if (is_tok) begin
                        if (run_cnt == RUN_LAST) begin
                            state_nxt = LOCKED;
                            run_nxt   = '0;
                            gap_nxt   = '0;
                            emit      = 1'b1;
                            lock_set  = 1'b1;
                        end else begin
                            run_nxt = run_cnt + 4'd1;
                        end
                    end else begin
                        run_nxt   = '0;
                        slip      = 1'b1;
                        state_nxt = SLIP;
                    end
                end
                // The word strobed right after a slip mixes two alignments
                SLIP: state_nxt = HUNT;
                LOCKED: begin
                    if (is_tok) begin
                        gap_nxt = '0;
                        emit    = 1'b1;
                    end else if (gap_cnt == GAP_LAST) begin
                        state_nxt = HUNT;
                        run_nxt   = '0;
                        gap_nxt   = '0;
                        lock_clr  = 1'b1;
                    end else begin
                        gap_nxt = gap_cnt + 12'd1;
                        emit    = 1'b1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Registered symbol outputs; ctl is sticky across data symbols
    always_ff @(posedge clk_x5) begin
        if (reset) begin
            sym_valid_q <= 1'b0;
            data_q      <= '0;
            ctl_q       <= '0;
            de_q        <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            sym_valid_q <= emit;
            if (lock_set)      locked_q <= 1'b1;
            else if (lock_clr) locked_q <= 1'b0;
            if (emit) begin
                if (is_tok) begin
                    de_q   <= 1'b0;
                    data_q <= '0;
                    ctl_q  <= tok_ctl;
                end else begin
                    de_q   <= 1'b1;
                    data_q <= tmds_dec(word);
                end
            end else if (strobe && state_nxt != LOCKED) begin
                de_q   <= 1'b0;
                data_q <= '0;
            end
        end
    end

    assign bus.sym_valid = sym_valid_q;
    assign bus.data      = data_q;
    assign bus.ctl       = ctl_q;
    assign bus.de        = de_q;
    assign bus.locked    = locked_q;
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: one default instance and one with a
// short token gap, both fed the same serial stream.
module tb_tmds_channel_decoder;
    localparam logic [9:0] TOK00  = 10'b1101010100;
    localparam logic [9:0] TOK01  = 10'b0010101011;
    localparam logic [9:0] TOK11  = 10'b1010101011;
    localparam logic [9:0] DAT_EF = 10'b1011110000;  // decodes to 8'hEF
    localparam logic [9:0] DAT_10 = 10'b0111110000;  // decodes to 8'h10

    typedef struct {
        logic       de;
        logic [1:0] ctl;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       clk_x5 = 1'b0;
    logic       reset;
    logic [1:0] din;
    int         n_chk = 0, n_fail = 0;
    int         cyc = 0, drops_a = 0, sv_unlocked = 0;
    logic       lk_prev_a = 1'b0, lk_prev_b = 1'b0;
    ev_t        qa[$], qb[$], xq[$];
    bit         bq[$];

    always #4 clk_x5 = ~clk_x5;

    tmds_channel_decoder_if bus_a();
    tmds_channel_decoder_if bus_b();
    assign bus_a.din = din;
    assign bus_b.din = din;

    tmds_channel_decoder u_dut_a (.clk_x5(clk_x5), .reset(reset), .bus(bus_a));
    tmds_channel_decoder #(.CTL_RUN(8), .MAX_GAP(16)) u_dut_b (.clk_x5(clk_x5), .reset(reset), .bus(bus_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Capture every decoded symbol and watch lock edges
    always @(posedge clk_x5) begin
        #1;
        cyc++;
        if (reset) begin
            lk_prev_a = 1'b0;
            lk_prev_b = 1'b0;
        end else begin
            if (bus_a.sym_valid) qa.push_back('{de: bus_a.de, ctl: bus_a.ctl, data: bus_a.data, cyc: cyc});
            if (bus_b.sym_valid) qb.push_back('{de: bus_b.de, ctl: bus_b.ctl, data: bus_b.data, cyc: cyc});
            if (bus_a.locked && !lk_prev_a) chk("a_lock_rise_sv", bus_a.sym_valid, 1);
            if (bus_b.locked && !lk_prev_b) chk("b_lock_rise_sv", bus_b.sym_valid, 1);
            if (!bus_a.locked && lk_prev_a) drops_a++;
            if ((bus_a.sym_valid && !bus_a.locked) || (bus_b.sym_valid && !bus_b.locked)) sv_unlocked++;
            lk_prev_a = bus_a.locked;
            lk_prev_b = bus_b.locked;
        end
    end

    task automatic pair(input logic [1:0] p);
        @(negedge clk_x5);
        din = p;
    endtask

    // Append a symbol (bit 0 first) and drive all complete bit pairs
    task automatic send(input logic [9:0] s);
        logic [1:0] p;
        for (int i = 0; i < 10; i++) bq.push_back(s[i]);
        while (bq.size() >= 2) begin
            p = {bq[1], bq[0]};
            void'(bq.pop_front());
            void'(bq.pop_front());
            pair(p);
        end
    endtask

    task automatic lock_wait(input logic [9:0] tok, input bit on_b, output int n);
        n = 0;
        while (n < 120 && (on_b ? bus_b.locked : bus_a.locked) !== 1'b1) begin
            send(tok);
            n++;
        end
    endtask

    task automatic xp(input logic de, input logic [1:0] c, input logic [7:0] d);
        xq.push_back('{de: de, ctl: c, data: d, cyc: 0});
    endtask

    // Match captured symbols against xq, anchored on the first data symbol (xq index lead)
    task automatic cmp_seq(input string tag, input bit on_b, input int lead);
        ev_t q[$];
        int  k, off, nbad, ncmp;
        if (on_b) q = qb; else q = qa;
        k = -1;
        foreach (q[i]) if (k < 0 && q[i].de === 1'b1) k = i;
        off  = k - lead;
        nbad = 0;
        ncmp = 0;
        if (k >= 0 && off >= 0)
            for (int i = 0; i < xq.size() && off + i < q.size(); i++) begin
                ncmp++;
                if (q[off+i].de !== xq[i].de || q[off+i].ctl !== xq[i].ctl || q[off+i].data !== xq[i].data)
                    nbad++;
            end
        chk({tag, "_mism"}, nbad, 0);
        chk({tag, "_ncmp"}, ncmp, xq.size());
    endtask

    // Steady blanking on lane A after ~20 tokens: all control, one symbol every 5 cycles
    task automatic chk_blank(input string tag, input logic [1:0] c);
        int nbad, nint;
        nbad = 0;
        nint = 0;
        foreach (qa[i]) begin
            if (qa[i].de !== 1'b0 || qa[i].ctl !== c || qa[i].data !== 8'h00) nbad++;
            if (i > 0 && qa[i].cyc - qa[i-1].cyc != 5) nint++;
        end
        chk({tag, "_sym"}, nbad, 0);
        chk({tag, "_period"}, nint, 0);
        chk({tag, "_count"}, qa.size() >= 19 && qa.size() <= 21, 1);
    endtask

    task automatic rst_cycles(input int n);
        reset = 1'b1;
        repeat (n) pair(2'b00);
        reset = 1'b0;
        bq.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nd;
        din   = 2'b00;
        reset = 1'b1;

        // Reset state
        repeat (3) pair(2'b00);
        chk("rst_a_sv", bus_a.sym_valid, 0);
        chk("rst_a_data", bus_a.data, 0);
        chk("rst_a_ctl", bus_a.ctl, 0);
        chk("rst_a_de", bus_a.de, 0);
        chk("rst_a_locked", bus_a.locked, 0);
        chk("rst_b_sv", bus_b.sym_valid, 0);
        chk("rst_b_locked", bus_b.locked, 0);
        reset = 1'b0;

        // 1: blanking tokens from reset
        lock_wait(TOK00, 0, n);
        chk("t1_lock_min", n >= 8, 1);
        chk("t1_lock_max", n <= 102, 1);
        lock_wait(TOK00, 1, n);
        chk("t1_b_locked", bus_b.locked, 1);
        qa.delete();
        repeat (20) send(TOK00);
        chk_blank("t1", 2'b00);

        // 3: data decode, ctl held from preceding 11 tokens
        repeat (3) send(TOK11);
        qa.delete();
        qb.delete();
        xq.delete();
        xp(1'b1, 2'b11, 8'hEF);
        xp(1'b1, 2'b11, 8'h10);
        xp(1'b0, 2'b11, 8'h00);
        send(DAT_EF);
        send(DAT_10);
        repeat (3) send(TOK11);
        cmp_seq("t3_a", 0, 0);
        cmp_seq("t3_b", 1, 0);

        // 5: lock loss on the MAX_GAP=16 lane
        qa.delete();
        qb.delete();
        repeat (16) send(DAT_EF);
        send(TOK00);
        chk("t5_b_unlocked", bus_b.locked, 0);
        chk("t5_a_locked", bus_a.locked, 1);
        nd = 0;
        foreach (qb[i]) if (qb[i].de === 1'b1) nd++;
        chk("t5_b_data_syms", nd, 15);
        nd = 0;
        foreach (qa[i]) if (qa[i].de === 1'b1) nd++;
        chk("t5_a_data_syms", nd, 16);
        nd = qb.size();
        repeat (5) send(TOK00);
        chk("t5_b_sv_stopped", qb.size(), nd);
        lock_wait(TOK00, 1, n);
        chk("t5_relock", (6 + n) >= 8 && (6 + n) <= 10, 1);

        // 2: misaligned start with 01 tokens
        rst_cycles(3);
        chk("t2_rst_ctl", bus_a.ctl, 0);
        bq.push_back(1'b1);
        bq.push_back(1'b0);
        bq.push_back(1'b1);
        lock_wait(TOK01, 0, n);
        chk("t2_lock_min", n >= 8, 1);
        chk("t2_lock_max", n <= 102, 1);
        qa.delete();
        repeat (20) send(TOK01);
        chk_blank("t2", 2'b01);

        // 4: two sync-lane lines on lane A
        qa.delete();
        xq.delete();
        drops_a = 0;
        for (int l = 0; l < 2; l++) begin
            repeat (96) xp(1'b0, 2'b11, 8'h00);
            repeat (48) xp(1'b0, 2'b00, 8'h00);
            for (int j = 0; j < 640; j++) xp(1'b1, 2'b00, (j % 2) ? 8'h10 : 8'hEF);
            repeat (16) xp(1'b0, 2'b00, 8'h00);
        end
        for (int l = 0; l < 2; l++) begin
            repeat (96) send(TOK11);
            repeat (48) send(TOK00);
            for (int j = 0; j < 640; j++) send((j % 2) ? DAT_10 : DAT_EF);
            repeat (16) send(TOK00);
        end
        repeat (2) send(TOK00);
        cmp_seq("t4", 0, 144);
        chk("t4_lock_held", drops_a, 0);
        chk("t4_locked", bus_a.locked, 1);

        // 6: reset mid-frame while showing data with ctl=11
        repeat (4) send(TOK11);
        repeat (3) send(DAT_EF);
        chk("t6_pre_de", bus_a.de, 1);
        chk("t6_pre_ctl", bus_a.ctl, 2'b11);
        reset = 1'b1;
        pair(2'b00);
        chk("t6_sv", bus_a.sym_valid, 0);
        chk("t6_data", bus_a.data, 0);
        chk("t6_ctl", bus_a.ctl, 0);
        chk("t6_de", bus_a.de, 0);
        chk("t6_locked", bus_a.locked, 0);
        reset = 1'b0;
        bq.delete();
        lock_wait(TOK00, 0, n);
        chk("t6_relock_min", n >= 8, 1);
        chk("t6_relock_max", n <= 102, 1);

        chk("sv_without_lock", sv_unlocked, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
